// File: rtl/cmd_trace_capture.sv
// cmd_trace_capture: debug trace buffer for the command-submission path.
// Samples a probe vector into a circular RAM, freezes on a programmable
// trigger with a fixed pre-trigger history, then serves the frozen trace
// through a register-style read port indexed from the oldest sample.
module cmd_trace_capture #(
  parameter int PROBE_W  = 64,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 128,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [PROBE_W-1:0] i_probe,
  input  logic [PROBE_W-1:0] i_trig_value,
  input  logic [PROBE_W-1:0] i_trig_mask,
  input  logic [1:0]         i_trig_mode,
  input  logic               i_ext_trig,
  input  logic               i_arm,
  input  logic               i_abort,
  input  logic               i_rd_en,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [PROBE_W-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic [2:0]         o_state,
  output logic               o_done,
  output logic [AW-1:0]      o_trig_addr
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Samples written after the trigger sample to fill the whole buffer.
  localparam int            POST_N    = DEPTH - PRE_TRIG - 1;
  localparam logic [AW:0]   PRE_LAST  = (AW+1)'(PRE_TRIG);
  localparam logic [AW:0]   POST_LAST = (AW+1)'(POST_N);
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);

  state_t               state;
  logic [AW-1:0]        wr_ptr;
  logic [AW:0]          pre_cnt;
  logic [AW:0]          post_cnt;
  logic                 match_prev;
  logic                 match;
  logic                 trig_fire;
  logic                 writing;
  logic [AW-1:0]        rd_phys;
  logic [PROBE_W-1:0]   ram [DEPTH];

  assign o_state = state;
  assign match   = ((i_probe ^ i_trig_value) & i_trig_mask) == '0;
  assign writing = ((state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST)) && !i_abort;
  // Physical address of logical index i_rd_addr; wraps naturally in AW bits.
  assign rd_phys = o_trig_addr - PRE_OFS + i_rd_addr;

  // Trigger decode; only consulted while waiting for the trigger.
  always_comb begin
    trig_fire = 1'b0;
    case (i_trig_mode)
      2'd0:    trig_fire = 1'b1;
      2'd1:    trig_fire = match;
      2'd2:    trig_fire = match && !match_prev;
      default: trig_fire = i_ext_trig;
    endcase
  end

  // Capture FSM: pointers, counters, trigger address and done flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      match_prev  <= 1'b0;
      o_trig_addr <= '0;
      o_done      <= 1'b0;
    end else if (i_abort) begin
      state  <= ST_IDLE;
      o_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_arm) begin
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            match_prev <= 1'b0;
            o_done     <= 1'b0;
            state      <= (PRE_TRIG == 0) ? ST_WAIT : ST_PRE;
          end
        end
        ST_PRE: begin
          wr_ptr     <= wr_ptr + PTR_ONE;
          pre_cnt    <= pre_cnt + CNT_ONE;
          match_prev <= match;
          if (pre_cnt + CNT_ONE == PRE_LAST) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wr_ptr     <= wr_ptr + PTR_ONE;
          match_prev <= match;
          if (trig_fire) begin
            o_trig_addr <= wr_ptr;
            if (POST_N == 0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          wr_ptr   <= wr_ptr + PTR_ONE;
          post_cnt <= post_cnt + CNT_ONE;
          if (post_cnt + CNT_ONE == POST_LAST) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sample RAM write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (writing) begin
      ram[wr_ptr] <= i_probe;
    end
  end

  // Read port: one-cycle latency, data holds when no read is accepted.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= 1'b0;
      if (i_rd_en && (state == ST_DONE)) begin
        o_rd_valid <= 1'b1;
        o_rd_data  <= ram[rd_phys];
      end
    end
  end

endmodule
